// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, MIPS-style opcode/funct constants and
// the decoded control bundle (with its bubble value). The decoder, the
// ID/EX operand stage, the ALU and the EX/MEM stage all use these.
package alu_pkg;

    // ALU function codes. Bit 3 selects "invert operand 2 + carry-in",
    // which is why SUB is ADD with the top bit set.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_XNOR = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_XNOR = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Destination select
    localparam logic DEST_RT = 1'b0;
    localparam logic DEST_RD = 1'b1;

    // Decoded control for one instruction.
    typedef struct packed {
        logic [3:0] alu_func;
        logic       imm_sext;   // 1: sign-extend immediate, 0: zero-extend
        logic       uses_imm;   // In2 comes from the immediate
        logic       uses_rt;    // instruction reads rt (load-use check)
        logic       dest_sel;   // DEST_RT / DEST_RD
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    // Control value of an empty pipeline slot.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_func:  ALU_AND,
        imm_sext:  1'b0,
        uses_imm:  1'b0,
        uses_rt:   1'b0,
        dest_sel:  DEST_RT,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        illegal:   1'b0
    };

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode/funct decoder feeding the ID/EX
// register.
//   opcode_i  instruction opcode
//   funct_i   R-type funct field
//   ctrl_o    decoded control bundle (ALU function, immediate handling,
//             rt usage, destination select, enables, illegal flag)
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // Undecodable default: ADD, no side effects, flagged illegal.
        ctrl_o           = CTRL_BUBBLE;
        ctrl_o.alu_func  = ALU_ADD;
        ctrl_o.illegal   = 1'b1;

        unique case (opcode_i)
            OP_RTYPE: begin
                // R-type always reads rt, even if the funct turns out illegal.
                ctrl_o.uses_rt  = 1'b1;
                ctrl_o.dest_sel = DEST_RD;
                ctrl_o.illegal  = 1'b0;
                ctrl_o.reg_write = 1'b1;
                unique case (funct_i)
                    FN_ADD:  ctrl_o.alu_func = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_func = ALU_SUB;
                    FN_AND:  ctrl_o.alu_func = ALU_AND;
                    FN_OR:   ctrl_o.alu_func = ALU_OR;
                    FN_XOR:  ctrl_o.alu_func = ALU_XOR;
                    FN_XNOR: ctrl_o.alu_func = ALU_XNOR;
                    FN_SLT:  ctrl_o.alu_func = ALU_SLT;
                    default: begin
                        ctrl_o.alu_func  = ALU_ADD;
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.illegal   = 1'b0;
                ctrl_o.uses_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm_sext  = (opcode_i == OP_ADDI) || (opcode_i == OP_SLTI);
                unique case (opcode_i)
                    OP_ADDI: ctrl_o.alu_func = ALU_ADD;
                    OP_SLTI: ctrl_o.alu_func = ALU_SLT;
                    OP_ANDI: ctrl_o.alu_func = ALU_AND;
                    OP_ORI:  ctrl_o.alu_func = ALU_OR;
                    default: ctrl_o.alu_func = ALU_XOR;
                endcase
            end
            OP_LW: begin
                ctrl_o.illegal   = 1'b0;
                ctrl_o.uses_imm  = 1'b1;
                ctrl_o.imm_sext  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
            end
            OP_SW: begin
                // Address from the immediate; rt is the store data.
                ctrl_o.illegal   = 1'b0;
                ctrl_o.uses_imm  = 1'b1;
                ctrl_o.imm_sext  = 1'b1;
                ctrl_o.uses_rt   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                // Compare rs - rt; no immediate on the ALU path.
                ctrl_o.illegal  = 1'b0;
                ctrl_o.alu_func = ALU_SUB;
                ctrl_o.uses_rt  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register directly feeding a purely
// combinational ALU. Decodes on the ID side, registers the instruction and
// register-file operands, then applies EX/MEM and MEM/WB forwarding on the
// registered indices to produce In1/In2. Detects load-use hazards and
// inserts a bubble.
//   clk, rst                 clock, async active-high reset
//   stall_i / flush_i        hold register / load bubble (flush wins)
//   id_*                     decoded-slot inputs from ID
//   exmem_* / memwb_*        forwarding sources
//   In1, In2, ALU_Func       ALU operands and function
//   ex_*                     EX-slot control for later stages
//   load_use_stall_o         request IF/ID hold
module id_ex_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [5:0]        id_opcode_i,
    input  logic [5:0]        id_funct_i,
    input  logic [IDX_W-1:0]  id_rs_idx_i,
    input  logic [IDX_W-1:0]  id_rt_idx_i,
    input  logic [IDX_W-1:0]  id_rd_idx_i,
    input  logic [15:0]       id_imm_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [IDX_W-1:0]  exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [IDX_W-1:0]  memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] In1,
    output logic [DATA_W-1:0] In2,
    output logic [3:0]        ALU_Func,
    output logic              ex_valid_o,
    output logic [IDX_W-1:0]  ex_dest_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic              ex_illegal_o,
    output logic              load_use_stall_o
);

    // Contents of the EX slot. The immediate is kept raw and extended after
    // the register so a bubble really is all zeros.
    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_func;
        logic              imm_sext;
        logic              uses_imm;
        logic [IDX_W-1:0]  dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              illegal;
        logic [IDX_W-1:0]  rs_idx;
        logic [IDX_W-1:0]  rt_idx;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [15:0]       imm;
    } ex_slot_t;

    ctrl_t    id_ctrl;
    ex_slot_t bubble;
    ex_slot_t id_slot;
    ex_slot_t slot_d, slot_q;

    alu_ctrl_decode u_dec (
        .opcode_i (id_opcode_i),
        .funct_i  (id_funct_i),
        .ctrl_o   (id_ctrl)
    );

    always_comb begin
        bubble          = '0;
        bubble.alu_func = CTRL_BUBBLE.alu_func;

        id_slot           = '0;
        id_slot.valid     = 1'b1;
        id_slot.alu_func  = id_ctrl.alu_func;
        id_slot.imm_sext  = id_ctrl.imm_sext;
        id_slot.uses_imm  = id_ctrl.uses_imm;
        id_slot.dest      = (id_ctrl.dest_sel == DEST_RD) ? id_rd_idx_i : id_rt_idx_i;
        id_slot.reg_write = id_ctrl.reg_write;
        id_slot.mem_read  = id_ctrl.mem_read;
        id_slot.mem_write = id_ctrl.mem_write;
        id_slot.illegal   = id_ctrl.illegal;
        id_slot.rs_idx    = id_rs_idx_i;
        id_slot.rt_idx    = id_rt_idx_i;
        id_slot.rs_data   = id_rs_data_i;
        id_slot.rt_data   = id_rt_data_i;
        id_slot.imm       = id_imm_i;
    end

    // Load-use: the load in EX has not produced its data yet, so a consumer
    // in ID must wait one cycle. Index 0 is never a real dependency.
    always_comb begin
        load_use_stall_o = slot_q.valid && slot_q.mem_read &&
                           (slot_q.dest != '0) && id_valid_i &&
                           ((id_rs_idx_i == slot_q.dest) ||
                            (id_ctrl.uses_rt && (id_rt_idx_i == slot_q.dest)));
    end

    always_comb begin
        slot_d = slot_q;
        if (flush_i)
            slot_d = bubble;
        else if (stall_i)
            slot_d = slot_q;
        else if (load_use_stall_o || !id_valid_i)
            slot_d = bubble;
        else
            slot_d = id_slot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    // EX/MEM beats MEM/WB; r0 never forwards.
    function automatic logic [DATA_W-1:0] fwd(input logic [IDX_W-1:0]  idx,
                                              input logic [DATA_W-1:0] reg_val);
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idx))
            return exmem_result_i;
        else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idx))
            return memwb_result_i;
        else
            return reg_val;
    endfunction

    logic [DATA_W-1:0] rs_fwd, rt_fwd, imm_ext;

    always_comb begin
        rs_fwd  = fwd(slot_q.rs_idx, slot_q.rs_data);
        rt_fwd  = fwd(slot_q.rt_idx, slot_q.rt_data);
        imm_ext = {{(DATA_W-16){slot_q.imm_sext & slot_q.imm[15]}}, slot_q.imm};
    end

    assign In1             = rs_fwd;
    assign In2             = slot_q.uses_imm ? imm_ext : rt_fwd;
    assign ALU_Func        = slot_q.alu_func;
    assign ex_valid_o      = slot_q.valid;
    assign ex_dest_o       = slot_q.dest;
    assign ex_reg_write_o  = slot_q.reg_write;
    assign ex_mem_read_o   = slot_q.mem_read;
    assign ex_mem_write_o  = slot_q.mem_write;
    assign ex_store_data_o = rt_fwd;
    assign ex_illegal_o    = slot_q.illegal;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i, flush_i, id_valid_i;
    logic [5:0]        id_opcode_i, id_funct_i;
    logic [IDX_W-1:0]  id_rs_idx_i, id_rt_idx_i, id_rd_idx_i;
    logic [15:0]       id_imm_i;
    logic [DATA_W-1:0] id_rs_data_i, id_rt_data_i;
    logic              exmem_reg_write_i, memwb_reg_write_i;
    logic [IDX_W-1:0]  exmem_rd_i, memwb_rd_i;
    logic [DATA_W-1:0] exmem_result_i, memwb_result_i;
    logic [DATA_W-1:0] In1, In2, ex_store_data_o;
    logic [3:0]        ALU_Func;
    logic              ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
    logic              ex_illegal_o, load_use_stall_o;
    logic [IDX_W-1:0]  ex_dest_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i), .id_funct_i(id_funct_i),
        .id_rs_idx_i(id_rs_idx_i), .id_rt_idx_i(id_rt_idx_i), .id_rd_idx_i(id_rd_idx_i),
        .id_imm_i(id_imm_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .In1(In1), .In2(In2), .ALU_Func(ALU_Func), .ex_valid_o(ex_valid_o),
        .ex_dest_o(ex_dest_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_store_data_o(ex_store_data_o), .ex_illegal_o(ex_illegal_o),
        .load_use_stall_o(load_use_stall_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid_i   = 1'b1;
        id_opcode_i  = op;   id_funct_i   = fn;
        id_rs_idx_i  = rs;   id_rt_idx_i  = rt;  id_rd_idx_i = rd;
        id_imm_i     = imm;
        id_rs_data_i = rsd;  id_rt_data_i = rtd;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 0; flush_i = 0; id_valid_i = 0;
        id_opcode_i = 0; id_funct_i = 0; id_rs_idx_i = 0; id_rt_idx_i = 0; id_rd_idx_i = 0;
        id_imm_i = 0; id_rs_data_i = 0; id_rt_data_i = 0;
        exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
        memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
        step(); step();
        checks++; if ({In1, In2, ALU_Func} !== '0) begin errors++;
            $display("FAIL reset_operands In1=%h In2=%h ALU_Func=%b expected zeros", In1, In2, ALU_Func); end
        checks++; if ({ex_valid_o, ex_dest_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
                       ex_store_data_o, ex_illegal_o, load_use_stall_o} !== '0) begin errors++;
            $display("FAIL reset_ex valid=%b dest=%0d stall=%b expected zeros", ex_valid_o, ex_dest_o, load_use_stall_o); end
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    task automatic test_rtype_and();
        drive_id(6'h00, 6'h24, 5'd1, 5'd2, 5'd7, 16'h0, 32'd5, 32'd10);
        step();
        checks++; if (In1 !== 32'd5 || In2 !== 32'd10) begin errors++;
            $display("FAIL and_operands In1=%0d In2=%0d expected 5 10", In1, In2); end
        checks++; if (ALU_Func !== 4'b0000 || ex_dest_o !== 5'd7 || ex_valid_o !== 1'b1 || ex_reg_write_o !== 1'b1) begin errors++;
            $display("FAIL and_ctrl func=%b dest=%0d valid=%b rw=%b expected 0000 7 1 1", ALU_Func, ex_dest_o, ex_valid_o, ex_reg_write_o); end
    endtask

    task automatic test_imm_ext();
        drive_id(6'h0D, 6'h00, 5'd1, 5'd6, 5'd0, 16'h8000, 32'd0, 32'h1234);
        step();
        checks++; if (In2 !== 32'h0000_8000 || ALU_Func !== 4'b0001 || ex_dest_o !== 5'd6) begin errors++;
            $display("FAIL ori_zext In2=%h func=%b dest=%0d expected 00008000 0001 6", In2, ALU_Func, ex_dest_o); end
        drive_id(6'h08, 6'h00, 5'd1, 5'd6, 5'd0, 16'h8000, 32'd0, 32'h1234);
        step();
        checks++; if (In2 !== 32'hFFFF_8000 || ALU_Func !== 4'b0100) begin errors++;
            $display("FAIL addi_sext In2=%h func=%b expected ffff8000 0100", In2, ALU_Func); end
    endtask

    task automatic test_forwarding();
        drive_id(6'h00, 6'h20, 5'd3, 5'd5, 5'd9, 16'h0, 32'h99, 32'h55);
        step();
        exmem_reg_write_i = 1; exmem_rd_i = 5'd3; exmem_result_i = 32'h11;
        memwb_reg_write_i = 1; memwb_rd_i = 5'd3; memwb_result_i = 32'h22;
        #1;
        checks++; if (In1 !== 32'h11) begin errors++;
            $display("FAIL fwd_exmem_prio In1=%h expected 11", In1); end
        exmem_rd_i = 5'd0; #1;
        checks++; if (In1 !== 32'h22) begin errors++;
            $display("FAIL fwd_memwb In1=%h expected 22", In1); end
        memwb_rd_i = 5'd0; #1;
        checks++; if (In1 !== 32'h99) begin errors++;
            $display("FAIL fwd_none In1=%h expected 99", In1); end
        // rt forwarding reaches store data and In2 of an R-type
        memwb_rd_i = 5'd5; #1;
        checks++; if (ex_store_data_o !== 32'h22 || In2 !== 32'h22) begin errors++;
            $display("FAIL fwd_rt store=%h In2=%h expected 22 22", ex_store_data_o, In2); end
        exmem_reg_write_i = 0; memwb_reg_write_i = 0; exmem_rd_i = 0; memwb_rd_i = 0;
    endtask

    task automatic test_load_use();
        drive_id(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 16'h0004, 32'h100, 32'h0);
        step();
        checks++; if (ex_mem_read_o !== 1'b1 || ex_dest_o !== 5'd4 || In2 !== 32'd4) begin errors++;
            $display("FAIL lw_ctrl mr=%b dest=%0d In2=%h expected 1 4 4", ex_mem_read_o, ex_dest_o, In2); end
        // addi reading r1, writing r4: rt is not a source, no hazard
        drive_id(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 16'h1, 32'h0, 32'h0); #1;
        checks++; if (load_use_stall_o !== 1'b0) begin errors++;
            $display("FAIL lu_addi_rt stall=%b expected 0", load_use_stall_o); end
        // sw storing r4 reads rt
        drive_id(6'h2B, 6'h00, 5'd1, 5'd4, 5'd0, 16'h0, 32'h0, 32'h0); #1;
        checks++; if (load_use_stall_o !== 1'b1) begin errors++;
            $display("FAIL lu_sw_rt stall=%b expected 1", load_use_stall_o); end
        drive_id(6'h00, 6'h20, 5'd4, 5'd2, 5'd8, 16'h0, 32'h0, 32'h0); #1;
        checks++; if (load_use_stall_o !== 1'b1) begin errors++;
            $display("FAIL lu_add_rs stall=%b expected 1", load_use_stall_o); end
        step();
        checks++; if (ex_valid_o !== 1'b0 || ALU_Func !== 4'b0000 || load_use_stall_o !== 1'b0) begin errors++;
            $display("FAIL lu_bubble valid=%b func=%b stall=%b expected 0 0000 0", ex_valid_o, ALU_Func, load_use_stall_o); end
        step();
        checks++; if (ex_valid_o !== 1'b1 || ex_dest_o !== 5'd8 || ALU_Func !== 4'b0100) begin errors++;
            $display("FAIL lu_resume valid=%b dest=%0d func=%b expected 1 8 0100", ex_valid_o, ex_dest_o, ALU_Func); end
    endtask

    task automatic test_stall_flush();
        drive_id(6'h00, 6'h24, 5'd1, 5'd2, 5'd7, 16'h0, 32'd5, 32'd10);
        step();
        stall_i = 1; flush_i = 1;
        step();
        checks++; if (ex_valid_o !== 1'b0 || ex_dest_o !== 5'd0 || In1 !== 32'd0) begin errors++;
            $display("FAIL stall_flush valid=%b dest=%0d In1=%h expected 0 0 0", ex_valid_o, ex_dest_o, In1); end
        stall_i = 0; flush_i = 0;
        drive_id(6'h00, 6'h26, 5'd3, 5'd4, 5'd12, 16'h0, 32'hAA, 32'hBB);
        step();
        stall_i = 1;
        drive_id(6'h00, 6'h22, 5'd6, 5'd7, 5'd13, 16'h0, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ALU_Func !== 4'b0010 || In1 !== 32'hAA || In2 !== 32'hBB || ex_dest_o !== 5'd12) begin errors++;
                $display("FAIL stall_hold cyc=%0d func=%b In1=%h In2=%h dest=%0d expected 0010 aa bb 12",
                         i, ALU_Func, In1, In2, ex_dest_o); end
        end
        stall_i = 0;
    endtask

    task automatic test_illegal();
        drive_id(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 32'h0);
        step();
        checks++; if (ex_illegal_o !== 1'b1 || ex_reg_write_o !== 1'b0 || ALU_Func !== 4'b0100) begin errors++;
            $display("FAIL illegal_funct ill=%b rw=%b func=%b expected 1 0 0100", ex_illegal_o, ex_reg_write_o, ALU_Func); end
        id_valid_i = 0;
        step();
        checks++; if (ex_valid_o !== 1'b0 || ex_illegal_o !== 1'b0) begin errors++;
            $display("FAIL id_invalid valid=%b ill=%b expected 0 0", ex_valid_o, ex_illegal_o); end
    endtask

    task automatic test_async_reset();
        drive_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'h77, 32'h66);
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (ex_valid_o !== 1'b0 || In1 !== 32'd0 || In2 !== 32'd0 || ALU_Func !== 4'b0000 || ex_dest_o !== 5'd0) begin errors++;
            $display("FAIL async_reset valid=%b In1=%h In2=%h func=%b dest=%0d expected zeros",
                     ex_valid_o, In1, In2, ALU_Func, ex_dest_o); end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype_and();
        test_imm_ext();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that feeds the ALU directly.
- Latches the decoded instruction and register-file operands.
- Generates ALU_Func from opcode/funct and sign- or zero-extends the immediate.
- Applies EX/MEM and MEM/WB forwarding to produce the ALU operands In1 and In2.
- Detects load-use hazards and handles stall/flush, so the ALU itself stays purely combinational.

Parameters:
DATA_W, 32, operand/result width
IDX_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  downstream hold; register keeps its contents
flush_i  in  1  branch/exception squash; loads a bubble
id_valid_i  in  1  ID slot holds a real instruction
id_opcode_i  in  6  opcode
id_funct_i  in  6  R-type funct
id_rs_idx_i  in  IDX_W  source 1 index
id_rt_idx_i  in  IDX_W  source 2 index
id_rd_idx_i  in  IDX_W  R-type destination
id_imm_i  in  16  immediate
id_rs_data_i  in  DATA_W  register-file read 1
id_rt_data_i  in  DATA_W  register-file read 2
exmem_reg_write_i  in  1  EX/MEM writes a register
exmem_rd_i  in  IDX_W  EX/MEM destination
exmem_result_i  in  DATA_W  EX/MEM ALU result
memwb_reg_write_i  in  1  MEM/WB writes a register
memwb_rd_i  in  IDX_W  MEM/WB destination
memwb_result_i  in  DATA_W  MEM/WB writeback value
In1  out  DATA_W  ALU operand 1
In2  out  DATA_W  ALU operand 2
ALU_Func  out  4  ALU function code
ex_valid_o  out  1  EX slot valid
ex_dest_o  out  IDX_W  destination index
ex_reg_write_o  out  1  instruction writes a register
ex_mem_read_o  out  1  load
ex_mem_write_o  out  1  store
ex_store_data_o  out  DATA_W  forwarded rt value for stores
ex_illegal_o  out  1  undecodable instruction
load_use_stall_o  out  1  request IF/ID hold; this stage inserts a bubble

Behaviour:
- ALU_Func codes: AND 0000, OR 0001, XOR 0010, XNOR 0011, ADD 0100, SUB 1100, SLT 0101.
- Decode, opcode 0x00 (R-type), by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 XNOR, 0x2A SLT.
  - dest = rd, reg_write = 1.
- Decode, I-type (dest = rt):
  - 0x08 addi ADD, sign-extended immediate, reg_write = 1.
  - 0x0A slti SLT, sign-extended, reg_write = 1.
  - 0x0C andi AND, zero-extended, reg_write = 1.
  - 0x0D ori OR, zero-extended, reg_write = 1.
  - 0x0E xori XOR, zero-extended, reg_write = 1.
  - 0x23 lw ADD, sign-extended, reg_write = 1, mem_read = 1.
  - 0x2B sw ADD, sign-extended, mem_write = 1, reg_write = 0.
  - 0x04 beq SUB, In2 = rt operand, reg_write = 0.
- Any other opcode/funct: ALU_Func = ADD, all write enables 0, ex_illegal_o = 1.
- Register update priority (per edge): rst > flush_i > stall_i > load-use bubble > load from ID.
  - Bubble: valid 0; all indices, data and immediate 0; all enables 0; ALU_Func AND; illegal 0.
  - id_valid_i = 0 also loads a bubble.
- Reset: all state cleared to the bubble state.
  - In1/In2 = 0, ALU_Func = 0000, all ex_* outputs = 0, load_use_stall_o = 0.
  - Reset asserted mid-operation discards the in-flight instruction immediately (asynchronous).
- Latency: ID inputs reach In1/In2/ALU_Func one cycle after capture.
- Forwarding (combinational on registered indices), per operand:
  - If exmem_reg_write_i and exmem_rd_i != 0 and exmem_rd_i == index: use exmem_result_i.
  - Else if the same test passes for MEM/WB: use memwb_result_i.
  - Else use the registered register-file value.
  - EX/MEM has priority over MEM/WB; index 0 never forwards.
- In1 = forwarded rs; In2 = extended immediate for I-type ALU/lw/sw, else forwarded rt.
- ex_store_data_o = forwarded rt in all cases.
- load_use_stall_o (combinational) = ex_valid_o & ex_mem_read_o & ex_dest_o != 0 & id_valid_i, and either:
  - id_rs_idx_i == ex_dest_o, or
  - the ID instruction reads rt (R-type, sw, beq) and id_rt_idx_i == ex_dest_o.
- While stall_i = 1, load_use_stall_o still reflects the current state, but the register holds.

Decomposition:
- Shared package alu_pkg:
  - ALU_Func code constants, opcode and funct constants.
  - Bubble control value.
  - Reused by ALU and the EX/MEM stage.
- One sub-module: alu_ctrl_decode.
  - Combinational: opcode/funct → ALU_Func, imm_sext, uses_rt, dest_sel, reg_write, mem_read, mem_write, illegal.
  - Instantiated on the ID side, before the register.

Test Plan:
- Reset, then R-type AND with rs = 1 (5), rt = 2 (10) → next cycle In1 = 5, In2 = 10, ALU_Func = 0000, ex_dest_o = rd.
- ori, rs data 0, imm 0x8000 → In2 = 0x00008000; addi, imm 0x8000 → In2 = 0xFFFF8000, ALU_Func = 0100.
- Registered rs = 3 with exmem (rd 3, 0x11) and memwb (rd 3, 0x22) both writing → In1 = 0x11; exmem_rd_i = 0 instead → In1 = 0x22; memwb also index 0 → In1 = register value.
- lw to r4 in EX, ID holds add using r4 → load_use_stall_o = 1; next cycle ex_valid_o = 0, ALU_Func = 0000.
- stall_i and flush_i asserted together → bubble loaded; stall_i alone for 3 cycles → outputs unchanged.
- Illegal funct 0x3F → ex_illegal_o = 1, ex_reg_write_o = 0, ALU_Func = 0100.
- rst asserted between clock edges → all outputs 0 immediately, without waiting for an edge.
